game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_controller.sv | 127 ++++++++++++
 tb/tb_game_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Game flow controller: sequences IDLE -> PLAY -> DYING -> OVER -> IDLE,
// keeps the BCD score and best score, and gates scrolling/physics per state.
module game_controller #(
    parameter int unsigned DEATH_FRAMES   = 60,
    parameter int unsigned HOLDOFF_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       flap,
    input  logic       collision,
    input  logic       pipe_passed,
    output logic [1:0] state,
    output logic       scroll_en,
    output logic       physics_en,
    output logic       flap_out,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic       new_best
);

    localparam int unsigned MAX_FRAMES =
        (DEATH_FRAMES > HOLDOFF_FRAMES) ? DEATH_FRAMES : HOLDOFF_FRAMES;
    localparam int unsigned CNT_W = (MAX_FRAMES < 2) ? 1 : $clog2(MAX_FRAMES + 1);

    // Counter value on which the DEATH_FRAMES-th tick lands in DYING.
    localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(HOLDOFF_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StPlay  = 2'b01,
        StDying = 2'b10,
        StOver  = 2'b11
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] frame_cnt;
    // Start-of-game flap is forwarded one cycle after entering PLAY.
    logic             start_pending;

    // Two-digit BCD increment, saturating at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99) return v;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign state = state_q;

    // Single-process FSM; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            frame_cnt     <= '0;
            start_pending <= 1'b0;
            flap_out      <= 1'b0;
            scroll_en     <= 1'b0;
            physics_en    <= 1'b0;
            score         <= 8'h00;
            high_score    <= 8'h00;
            new_best      <= 1'b0;
        end else begin
            flap_out      <= 1'b0;
            start_pending <= 1'b0;
            case (state_q)
                StIdle: begin
                    scroll_en  <= 1'b0;
                    physics_en <= 1'b0;
                    if (flap) begin
                        state_q       <= StPlay;
                        score         <= 8'h00;
                        new_best      <= 1'b0;
                        start_pending <= 1'b1;
                        frame_cnt     <= '0;
                        scroll_en     <= 1'b1;
                        physics_en    <= 1'b1;
                    end
                end
                StPlay: begin
                    flap_out <= flap | start_pending;
                    if (collision) begin
                        // Collision wins over a simultaneous pipe_passed.
                        state_q   <= StDying;
                        frame_cnt <= '0;
                        scroll_en <= 1'b0;
                    end else if (pipe_passed) begin
                        score <= bcd_inc(score);
                    end
                end
                StDying: begin
                    if (frame_tick) begin
                        if (frame_cnt == DEATH_LAST) begin
                            state_q    <= StOver;
                            frame_cnt  <= '0;
                            physics_en <= 1'b0;
                            // Valid BCD orders the same as binary.
                            if (score > high_score) begin
                                high_score <= score;
                                new_best   <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + CNT_ONE;
                        end
                    end
                end
                StOver: begin
                    // Flap is judged against the counter before this cycle's tick.
                    if (flap && frame_cnt == HOLD_MAX) begin
                        state_q   <= StIdle;
                        frame_cnt <= '0;
                    end else if (frame_tick && frame_cnt < HOLD_MAX) begin
                        frame_cnt <= frame_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    frame_cnt  <= '0;
                    scroll_en  <= 1'b0;
                    physics_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: three games plus a reset mid-DYING.
module tb_game_controller;

    logic       clk = 1'b0;
    logic       reset, frame_tick, flap, collision, pipe_passed;
    logic [1:0] state;
    logic       scroll_en, physics_en, flap_out, new_best;
    logic [7:0] score, high_score;

    int pass_cnt = 0;
    int total    = 0;

    game_controller #(.DEATH_FRAMES(60), .HOLDOFF_FRAMES(30)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .flap       (flap),
        .collision  (collision),
        .pipe_passed(pipe_passed),
        .state      (state),
        .scroll_en  (scroll_en),
        .physics_en (physics_en),
        .flap_out   (flap_out),
        .score      (score),
        .high_score (high_score),
        .new_best   (new_best)
    );

    always #20 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic pipes(input int n);
        for (int i = 0; i < n; i++) begin
            pipe_passed = 1'b1;
            cyc();
            pipe_passed = 1'b0;
            cyc();
        end
    endtask

    task automatic press();
        flap = 1'b1;
        cyc();
        flap = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; flap = 1'b0; collision = 1'b0; pipe_passed = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        check("rst_state", 8'(state), 8'h00);
        check("rst_score", score, 8'h00);
        check("rst_high", high_score, 8'h00);
        check("rst_new_best", 8'(new_best), 8'h00);
        check("rst_flap_out", 8'(flap_out), 8'h00);
        check("rst_scroll", 8'(scroll_en), 8'h00);
        check("rst_physics", 8'(physics_en), 8'h00);

        // Game A: start, score 5, die with simultaneous pipe/collision/tick.
        press();
        check("a_start_state", 8'(state), 8'h01);
        check("a_start_scroll", 8'(scroll_en), 8'h01);
        check("a_start_physics", 8'(physics_en), 8'h01);
        check("a_start_flap_out_early", 8'(flap_out), 8'h00);
        check("a_start_score", score, 8'h00);
        cyc();
        check("a_start_flap_out", 8'(flap_out), 8'h01);
        cyc();
        check("a_start_flap_out_end", 8'(flap_out), 8'h00);
        pipes(5);
        check("a_score5", score, 8'h05);
        press();
        check("a_play_flap_out", 8'(flap_out), 8'h01);
        cyc();
        check("a_play_flap_out_end", 8'(flap_out), 8'h00);
        pipe_passed = 1'b1; collision = 1'b1; frame_tick = 1'b1;
        cyc();
        pipe_passed = 1'b0; collision = 1'b0; frame_tick = 1'b0;
        check("a_collide_state", 8'(state), 8'h02);
        check("a_collide_score", score, 8'h05);
        check("a_collide_scroll", 8'(scroll_en), 8'h00);
        check("a_collide_physics", 8'(physics_en), 8'h01);
        flap = 1'b1; pipe_passed = 1'b1;
        cyc();
        flap = 1'b0; pipe_passed = 1'b0;
        cyc();
        check("a_dying_ign_score", score, 8'h05);
        check("a_dying_ign_flap_out", 8'(flap_out), 8'h00);
        check("a_dying_ign_state", 8'(state), 8'h02);
        ticks(59);
        check("a_dying59_state", 8'(state), 8'h02);
        ticks(1);
        check("a_over_state", 8'(state), 8'h03);
        check("a_over_high", high_score, 8'h05);
        check("a_over_new_best", 8'(new_best), 8'h01);
        check("a_over_physics", 8'(physics_en), 8'h00);
        check("a_over_scroll", 8'(scroll_en), 8'h00);
        ticks(10);
        press();
        cyc();
        check("a_holdoff_flap_ignored", 8'(state), 8'h03);
        ticks(25);  // 35 total; counter must sit at 30
        press();
        check("a_over_to_idle", 8'(state), 8'h00);
        check("a_idle_score_kept", score, 8'h05);
        cyc();
        check("a_idle_no_flap_out", 8'(flap_out), 8'h00);
        check("a_idle_new_best_held", 8'(new_best), 8'h01);
        check("a_idle_physics", 8'(physics_en), 8'h00);

        // Game B: score 3 against a best of 5.
        press();
        check("b_start_state", 8'(state), 8'h01);
        check("b_start_new_best", 8'(new_best), 8'h00);
        check("b_start_score", score, 8'h00);
        pipes(3);
        check("b_score3", score, 8'h03);
        collision = 1'b1;
        cyc();
        collision = 1'b0;
        ticks(60);
        check("b_over_state", 8'(state), 8'h03);
        check("b_over_high", high_score, 8'h05);
        check("b_over_new_best", 8'(new_best), 8'h00);
        ticks(30);
        press();
        check("b_over_to_idle", 8'(state), 8'h00);

        // Game C: BCD carry and saturation, then reset mid-DYING.
        press();
        cyc();
        pipes(9);
        check("c_score09", score, 8'h09);
        pipes(3);
        check("c_score12", score, 8'h12);
        pipes(87);
        check("c_score99", score, 8'h99);
        pipes(1);
        check("c_score_sat", score, 8'h99);
        collision = 1'b1;
        cyc();
        collision = 1'b0;
        ticks(20);
        check("c_dying_state", 8'(state), 8'h02);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("c_rst_state", 8'(state), 8'h00);
        check("c_rst_score", score, 8'h00);
        check("c_rst_high", high_score, 8'h00);
        check("c_rst_new_best", 8'(new_best), 8'h00);
        check("c_rst_physics", 8'(physics_en), 8'h00);
        check("c_rst_scroll", 8'(scroll_en), 8'h00);
        check("c_rst_flap_out", 8'(flap_out), 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
